// File: rtl/traffic_pkg.sv
// Shared types and default timing constants for the intersection controller.
package traffic_pkg;

   // Controller phases; ALLRED is the reset/clearance phase.
   typedef enum logic [1:0] {
      ST_ALLRED = 2'd0,
      ST_GREEN  = 2'd1,
      ST_YELLOW = 2'd2,
      ST_FLASH  = 2'd3
   } traffic_state_t;

   // Default phase durations, counted in tick pulses.
   localparam int DEF_N_DIR    = 2;
   localparam int DEF_GREEN_T  = 15;
   localparam int DEF_YELLOW_T = 5;
   localparam int DEF_ALLRED_T = 2;
   localparam int DEF_CNT_W    = 5;

endpackage

// File: rtl/rr_demand_select.sv
// Round-robin chooser: the first approach after cur_dir (wrapping) with demand.
// With no demand anywhere it simply advances to cur_dir+1 so service keeps rotating.
module rr_demand_select #(
   parameter int N_DIR = 2
) (
   input  logic [N_DIR-1:0]         demand,
   input  logic [$clog2(N_DIR)-1:0] cur_dir,
   output logic [$clog2(N_DIR)-1:0] next_dir
);

   localparam int DW = $clog2(N_DIR);

   // Offsets are scanned farthest-first so the nearest requesting approach wins last.
   always_comb begin
      next_dir = (cur_dir == DW'(N_DIR - 1)) ? '0 : cur_dir + DW'(1);
      for (int k = N_DIR; k >= 1; k--) begin
         for (int j = 0; j < N_DIR; j++) begin
            if (demand[j] && (((int'(cur_dir) + k) % N_DIR) == j)) begin
               next_dir = DW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// N-approach round-robin traffic controller with all-red clearance and flashing-yellow mode.
// Handshake: none; tick is a one-cycle enable pulse, demand and flash_req are levels
// sampled only at phase boundaries (ALLRED exit tick, and every tick while flashing).
module traffic_intersection_ctrl
   import traffic_pkg::*;
#(
   parameter int N_DIR    = DEF_N_DIR,
   parameter int GREEN_T  = DEF_GREEN_T,
   parameter int YELLOW_T = DEF_YELLOW_T,
   parameter int ALLRED_T = DEF_ALLRED_T,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic [N_DIR-1:0]         demand,
   input  logic                     flash_req,
   output logic [N_DIR-1:0]         red,
   output logic [N_DIR-1:0]         yellow,
   output logic [N_DIR-1:0]         green,
   output logic [$clog2(N_DIR)-1:0] cur_dir,
   output logic                     phase_done,
   output traffic_state_t           state_dbg
);

   localparam int DW = $clog2(N_DIR);
   localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(GREEN_T - 1);
   localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_T - 1);

   traffic_state_t   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]    dir_d, rr_next;
   logic             ph_q, ph_d;
   logic [N_DIR-1:0] red_d, yellow_d, green_d;
   logic             done_d;

   rr_demand_select #(.N_DIR(N_DIR)) u_sel (
      .demand   (demand),
      .cur_dir  (cur_dir),
      .next_dir (rr_next)
   );

   // State register; lamp outputs are registered alongside so they switch with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_ALLRED;
         cnt_q      <= '0;
         cur_dir    <= DW'(N_DIR - 1);
         ph_q       <= 1'b0;
         red        <= '1;
         yellow     <= '0;
         green      <= '0;
         phase_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cur_dir    <= dir_d;
         ph_q       <= ph_d;
         red        <= red_d;
         yellow     <= yellow_d;
         green      <= green_d;
         phase_done <= done_d;
      end
   end

   // Next-state logic: everything advances only on tick; counter clears on each state entry.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = cur_dir;
      ph_d    = ph_q;
      if (tick) begin
         cnt_d = cnt_q + 1'b1;
         case (state_q)
            ST_ALLRED: begin
               if (cnt_q == AR_LAST) begin
                  cnt_d = '0;
                  if (flash_req) begin
                     state_d = ST_FLASH;
                     ph_d    = 1'b1;
                  end else begin
                     state_d = ST_GREEN;
                     dir_d   = rr_next;
                  end
               end
            end
            ST_GREEN: begin
               if (cnt_q == G_LAST) begin
                  state_d = ST_YELLOW;
                  cnt_d   = '0;
               end
            end
            ST_YELLOW: begin
               if (cnt_q == Y_LAST) begin
                  state_d = ST_ALLRED;
                  cnt_d   = '0;
               end
            end
            default: begin
               if (!flash_req) begin
                  state_d = ST_ALLRED;
                  cnt_d   = '0;
                  ph_d    = 1'b0;
               end else begin
                  ph_d = ~ph_q;
               end
            end
         endcase
      end
   end

   // Output decode from the upcoming state so lamps are valid in the same cycle as the state.
   always_comb begin
      red_d    = '1;
      yellow_d = '0;
      green_d  = '0;
      done_d   = (state_q == ST_GREEN) && (state_d == ST_YELLOW);
      case (state_d)
         ST_GREEN: begin
            green_d[dir_d] = 1'b1;
            red_d[dir_d]   = 1'b0;
         end
         ST_YELLOW: begin
            yellow_d[dir_d] = 1'b1;
            red_d[dir_d]    = 1'b0;
         end
         ST_FLASH: begin
            red_d    = '0;
            yellow_d = {N_DIR{ph_d}};
         end
         default: ;
      endcase
   end

   assign state_dbg = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed bench for traffic_intersection_ctrl (N_DIR=3, GREEN_T=4, YELLOW_T=2, ALLRED_T=1).
module tb_traffic_intersection_ctrl;
   import traffic_pkg::*;

   logic           clk = 1'b0;
   logic           rst;
   logic           tick;
   logic [2:0]     demand;
   logic           flash_req;
   logic [2:0]     red, yellow, green;
   logic [1:0]     cur_dir;
   logic           phase_done;
   traffic_state_t state_dbg;

   int checks = 0;
   int errors = 0;

   // Clock and device under test.
   always #5 clk = ~clk;

   traffic_intersection_ctrl #(
      .N_DIR(3), .GREEN_T(4), .YELLOW_T(2), .ALLRED_T(1), .CNT_W(5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .demand     (demand),
      .flash_req  (flash_req),
      .red        (red),
      .yellow     (yellow),
      .green      (green),
      .cur_dir    (cur_dir),
      .phase_done (phase_done),
      .state_dbg  (state_dbg)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Safety invariant, checked every cycle on the falling edge.
   always @(negedge clk) begin
      chk("inv_no_green_and_yellow", 32'(green & yellow), 32'd0);
      chk("inv_lamp_pattern",
          32'(((red == ~(green | yellow)) && $onehot0(green | yellow)) ||
              ((red == 3'b000) && (green == 3'b000) && (yellow == 3'b000 || yellow == 3'b111))),
          32'd1);
   end

   initial begin
      rst = 1'b1; tick = 1'b1; demand = 3'b111; flash_req = 1'b0;
      step(2);
      chk("rst_red", 32'(red), 32'h7);
      chk("rst_yellow", 32'(yellow), 32'h0);
      chk("rst_green", 32'(green), 32'h0);
      chk("rst_cur_dir", 32'(cur_dir), 32'd2);
      chk("rst_phase_done", 32'(phase_done), 32'd0);

      // Full demand from reset.
      rst = 1'b0;
      step(1);  // cycle 1
      chk("c1_green", 32'(green), 32'h1);
      chk("c1_red", 32'(red), 32'h6);
      chk("c1_cur_dir", 32'(cur_dir), 32'd0);
      step(3);  // cycle 4
      chk("c4_green_held", 32'(green), 32'h1);
      chk("c4_no_done", 32'(phase_done), 32'd0);
      step(1);  // cycle 5
      chk("c5_yellow", 32'(yellow), 32'h1);
      chk("c5_green_off", 32'(green), 32'h0);
      chk("c5_done", 32'(phase_done), 32'd1);
      step(1);  // cycle 6
      chk("c6_done_pulse", 32'(phase_done), 32'd0);
      chk("c6_yellow", 32'(yellow), 32'h1);
      step(1);  // cycle 7
      chk("c7_allred", 32'(red), 32'h7);
      chk("c7_yellow_off", 32'(yellow), 32'h0);
      step(1);  // cycle 8
      chk("c8_green", 32'(green), 32'h2);
      chk("c8_cur_dir", 32'(cur_dir), 32'd1);

      // Skip: only approach 2 requests.
      demand = 3'b100;
      step(7);  // cycle 15
      chk("skip_green1", 32'(green), 32'h4);
      chk("skip_dir1", 32'(cur_dir), 32'd2);
      step(3);  // cycle 18
      chk("skip_red_others", 32'(red), 32'h3);
      step(3);  // cycle 21
      chk("skip_allred", 32'(red), 32'h7);
      step(1);  // cycle 22
      chk("skip_green2", 32'(green), 32'h4);

      // No demand: plain rotation.
      demand = 3'b000;
      step(7);  // cycle 29
      chk("nodem_g0", 32'(green), 32'h1);
      step(7);  // cycle 36
      chk("nodem_g1", 32'(green), 32'h2);
      step(7);  // cycle 43
      chk("nodem_g2", 32'(green), 32'h4);
      step(7);  // cycle 50
      chk("nodem_g0_again", 32'(green), 32'h1);

      // Flash requested mid-green.
      step(1);  // cycle 51
      flash_req = 1'b1;
      step(2);  // cycle 53
      chk("fl_green_not_cut", 32'(green), 32'h1);
      step(1);  // cycle 54
      chk("fl_yellow", 32'(yellow), 32'h1);
      chk("fl_done", 32'(phase_done), 32'd1);
      step(1);  // cycle 55
      chk("fl_yellow_full", 32'(yellow), 32'h1);
      step(1);  // cycle 56
      chk("fl_allred", 32'(red), 32'h7);
      step(1);  // cycle 57
      chk("fl_on_yellow", 32'(yellow), 32'h7);
      chk("fl_on_red", 32'(red), 32'h0);
      chk("fl_on_green", 32'(green), 32'h0);
      chk("fl_dir_kept", 32'(cur_dir), 32'd0);
      step(1);  // cycle 58
      chk("fl_off_yellow", 32'(yellow), 32'h0);
      chk("fl_off_red", 32'(red), 32'h0);
      step(1);  // cycle 59
      chk("fl_on2_yellow", 32'(yellow), 32'h7);
      flash_req = 1'b0;
      step(1);  // cycle 60
      chk("fl_exit_allred", 32'(red), 32'h7);
      chk("fl_exit_yellow", 32'(yellow), 32'h0);
      step(1);  // cycle 61
      chk("fl_exit_green", 32'(green), 32'h2);
      chk("fl_exit_dir", 32'(cur_dir), 32'd1);

      // Tick gating: one tick every 4 cycles from a fresh reset.
      rst = 1'b1;
      step(1);
      chk("tg_rst_red", 32'(red), 32'h7);
      rst = 1'b0; demand = 3'b111;
      for (int c = 1; c <= 18; c++) begin
         tick = ((c - 1) % 4 == 0);
         step(1);
         if (c == 1)  chk("tg_green_start", 32'(green), 32'h1);
         if (c == 8)  chk("tg_green_hold", 32'(green), 32'h1);
         if (c == 16) chk("tg_green_last", 32'(green), 32'h1);
         if (c == 17) begin
            chk("tg_yellow", 32'(yellow), 32'h1);
            chk("tg_done", 32'(phase_done), 32'd1);
         end
         if (c == 18) begin
            chk("tg_yellow_hold", 32'(yellow), 32'h1);
            chk("tg_done_clear", 32'(phase_done), 32'd0);
         end
      end

      // Reset asserted during yellow; ticks during reset are ignored.
      tick = 1'b1; rst = 1'b1;
      step(1);
      chk("mr_red", 32'(red), 32'h7);
      chk("mr_yellow", 32'(yellow), 32'h0);
      chk("mr_green", 32'(green), 32'h0);
      chk("mr_dir", 32'(cur_dir), 32'd2);
      step(2);
      chk("mr_hold_red", 32'(red), 32'h7);
      chk("mr_hold_green", 32'(green), 32'h0);
      rst = 1'b0;
      step(1);
      chk("mr_release_green", 32'(green), 32'h1);
      chk("mr_release_dir", 32'(cur_dir), 32'd0);

      // Randomised demand, tick and flash; the invariant block checks every cycle.
      for (int i = 0; i < 10000; i++) begin
         tick   = ($urandom_range(0, 3) != 0);
         demand = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 63) == 0) flash_req = ~flash_req;
         step(1);
      end
      flash_req = 1'b0;
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
